axi_lite_wr_sched: RTL and testbench
====================================

AXI_LITE_WR_SCHED -- requirements
Module: axi_lite_wr_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter AW, default 32, write address width.
REQ-003 Parameter DW, default 32, write data width.
REQ-004 Parameter TO_CYCLES, default 1024, watchdog limit in clk cycles (used only with WR_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester write request, held high until acknowledged.
REQ-008 req_addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-009 req_data  in  NREQ*DW  packed data, requester i at bits [i*DW +: DW].
REQ-010 req_ack  out  NREQ  one-cycle one-hot completion pulse to the granted requester.
REQ-011 req_err  out  1  valid only while any req_ack bit is high; 1 = write aborted.
REQ-012 gnt_id  out  clog2(NREQ)  index of the current or last granted requester.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 wr_start  out  1  one-cycle start pulse to the AXI-Lite write engine.
REQ-015 wr_addr  out  AW  latched address, stable from wr_start until ACK.
REQ-016 wr_data  out  DW  latched data, stable from wr_start until ACK.
REQ-017 wr_done  in  1  one-cycle completion pulse from the write engine (OKAY response received).

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and ACK.
REQ-019 IDLE: if any req bit is high, SHALL select the first set bit at or after rr_ptr (wrapping modulo NREQ), latch its addr/data into wr_addr/wr_data, latch its index into gnt_id, and go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE: wr_start SHALL be 1 for exactly this cycle; next state SHALL be WAIT.
REQ-021 WAIT: on wr_done=1 SHALL go to ACK with error flag 0; otherwise stay in WAIT.
REQ-022 wr_done SHALL be ignored in every state except WAIT.
REQ-023 ACK: req_ack[gnt_id] SHALL be 1 and req_err SHALL equal the error flag; rr_ptr SHALL become (gnt_id+1) mod NREQ; next state SHALL be IDLE.
REQ-024 Latency: req rising in IDLE at cycle 0 gives wr_start at cycle 1; wr_done at cycle k gives req_ack at cycle k+1.
REQ-025 A requester SHALL drop req on the edge at which it samples req_ack; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-026 Changes to req, req_addr or req_data after the grant SHALL NOT affect wr_addr, wr_data or gnt_id until the next IDLE.
REQ-027 With all NREQ requests held high, grants SHALL rotate 0,1,...,NREQ-1,0 with no requester granted twice before each other pending requester is granted once.
REQ-028 Exactly one transaction SHALL be outstanding at a time; wr_start SHALL NOT re-assert before the ACK of the previous transaction.

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, rr_ptr=0, gnt_id=0, wr_addr=0, wr_data=0, error flag=0; therefore wr_start=0, req_ack=0, req_err=0, busy=0.
REQ-030 rst asserted during ISSUE/WAIT/ACK SHALL abandon the transaction with no req_ack pulse; the write engine SHALL share the same rst.

Configuration
REQ-031 Macro WR_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT and increment each WAIT cycle; when it reaches TO_CYCLES without wr_done the FSM SHALL go to ACK with error flag 1 (req_err=1).
REQ-032 If wr_done and the timeout occur in the same cycle, wr_done SHALL win (req_err=0).
REQ-033 Macro WR_TIMEOUT_EN undefined: no counter SHALL be built, WAIT SHALL exit only on wr_done, and req_err SHALL be tied to 0.

Verification
REQ-034 Single request: req=4'b0100, addr 0x10, data 0xA5 at cycle 0, wr_done at cycle 4 -> wr_start at cycle 1 with wr_addr=0x10, wr_data=0xA5; req_ack=4'b0100, req_err=0 at cycle 5.
REQ-035 Round robin: req=4'b1111 held with wr_done 3 cycles after each wr_start -> gnt_id sequence 0,1,2,3,0.
REQ-036 Pointer wrap: after a grant to 3, req=4'b1001 -> next grant 0; after that grant, req=4'b1001 -> next grant 3.
REQ-037 Stability: req_addr changed one cycle after wr_start -> wr_addr unchanged until req_ack.
REQ-038 Timeout (WR_TIMEOUT_EN, TO_CYCLES=16): no wr_done -> req_ack with req_err=1 after 16 WAIT cycles; wr_done on the timeout cycle -> req_err=0.
REQ-039 Reset in WAIT: rst pulsed one cycle -> next cycle busy=0 and req_ack=0; pending req=4'b0010 -> grant 1 with wr_start one cycle after rst deasserts.

Source files
------------

// File: rtl/axi_lite_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_wr_sched
// Description : Round-robin scheduler that funnels single-beat write requests
//               from NREQ requesters into one AXI-Lite write engine. One
//               transaction is outstanding at a time.
// Optional    : define WR_TIMEOUT_EN to build a WAIT-state watchdog that
//               aborts a write after TO_CYCLES cycles (req_err_o = 1).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               req_i            - per-requester request (held until ack)
//               req_addr_i       - packed addresses, requester i at [i*AW +: AW]
//               req_data_i       - packed data, requester i at [i*DW +: DW]
//               req_ack_o        - one-cycle one-hot completion pulse
//               req_err_o        - abort flag, valid with req_ack_o
//               gnt_id_o         - current / last granted requester
//               busy_o           - scheduler not idle
//               wr_start_o       - one-cycle start pulse to the write engine
//               wr_addr_o/data_o - latched write address / data
//               wr_done_i        - completion pulse from the write engine
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_wr_sched #(
  parameter int NREQ      = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*AW-1:0]       req_addr_i,
  input  logic [NREQ*DW-1:0]       req_data_i,
  output logic [NREQ-1:0]          req_ack_o,
  output logic                     req_err_o,
  output logic [$clog2(NREQ)-1:0]  gnt_id_o,
  output logic                     busy_o,
  output logic                     wr_start_o,
  output logic [AW-1:0]            wr_addr_o,
  output logic [DW-1:0]            wr_data_o,
  input  logic                     wr_done_i
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;

`ifdef WR_TIMEOUT_EN
  localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0, take
  // the lowest set bit, then map the rotated offset back to a requester index.
  // --------------------------------------------------------------------------
  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_req_rot;
  logic              w_found;
  logic [IDW-1:0]    w_sel;
  logic [IDW:0]      w_sum;

  assign w_req_dbl = {req_i, req_i};
  assign w_req_rot = w_req_dbl[rr_ptr_q +: NREQ];

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_sel = w_sum[IDW-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      gnt_id_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef WR_TIMEOUT_EN
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_id_q  <= gnt_id_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef WR_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Address, data and grant index are captured only in
  // IDLE, so requester-side changes after the grant cannot leak through.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef WR_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          gnt_id_d  = w_sel;
          wr_addr_d = req_addr_i[int'(w_sel)*AW +: AW];
          wr_data_d = req_data_i[int'(w_sel)*DW +: DW];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef WR_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // wr_done has priority over a watchdog expiry in the same cycle.
        if (wr_done_i) begin
          state_d = S_ACK;
`ifdef WR_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (to_cnt_q == CNT_W'(TO_CYCLES - 1)) begin
          state_d = S_ACK;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
`endif
        end
      end
      S_ACK: begin
        if (gnt_id_q == IDW'(NREQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gnt_id_q + IDW'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy_o     = (state_q != S_IDLE);
  assign wr_start_o = (state_q == S_ISSUE);
  assign req_ack_o  = (state_q == S_ACK) ? (NREQ'(1) << gnt_id_q) : '0;
  assign gnt_id_o   = gnt_id_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

`ifdef WR_TIMEOUT_EN
  assign req_err_o  = (state_q == S_ACK) & err_q;
`else
  assign req_err_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_wr_sched
// Description : Directed bench for axi_lite_wr_sched. Expected grants are
//               queued when requests are raised and checked when the
//               scheduler issues and acknowledges each write. Define
//               WR_TIMEOUT_EN to exercise the watchdog (TO_CYCLES = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_wr_sched;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic               req_err;
  logic [1:0]         gnt_id;
  logic               busy;
  logic               wr_start;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               wr_done;

  axi_lite_wr_sched #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .TO_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .req_ack_o  (req_ack),
    .req_err_o  (req_err),
    .gnt_id_o   (gnt_id),
    .busy_o     (busy),
    .wr_start_o (wr_start),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .wr_done_i  (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [31:0] a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input int id, input logic [31:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    x.id = id; x.addr = a; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  // Advance until wr_start is seen (bounded); n = cycles taken.
  task automatic wait_start(input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wr_start && n < 50);
    chk("wr_start_seen", wr_start, 1'b1);
    if (exp_n > 0) chk("start_latency", n, exp_n);
  endtask

  // Called in the ISSUE cycle. wr_done is driven lat cycles after wr_start
  // (lat=0 means never); ghost drives a stray wr_done during ISSUE; mutate
  // scribbles over the granted requester's address/data after the grant.
  task automatic finish_txn(input int lat, input bit ghost, input bit mutate, input bit drop);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("gnt_id", gnt_id, e.id);
    chk("wr_addr_start", wr_addr, e.addr);
    chk("wr_data_start", wr_data, e.data);
    wr_done = ghost;
    tick();
    wr_done = 1'b0;
    chk("no_early_ack", req_ack, 0);
    chk("start_one_cycle", wr_start, 1'b0);
    if (mutate) set_src(e.id, ~e.addr, ~e.data);
    if (lat == 0) begin
      repeat (TO - 1) tick();
      chk("still_waiting", req_ack, 0);
      tick();
    end else begin
      repeat (lat - 1) tick();
      chk("busy_in_wait", busy, 1'b1);
      chk("no_ack_in_wait", req_ack, 0);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
    end
    chk("req_ack", req_ack, 4'(1) << e.id);
    chk("req_err", req_err, e.err);
    chk("wr_addr_ack", wr_addr, e.addr);
    chk("wr_data_ack", wr_data, e.data);
    if (drop) req[e.id] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0; wr_done = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", req_ack, 0);
    chk("rst_err", req_err, 1'b0);
    chk("rst_start", wr_start, 1'b0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);

    // Single request, exact latency: wr_start at cycle 1, ack at cycle 5.
    rst = 1'b0;
    set_src(2, 32'h10, 32'hA5);
    req = 4'b0100;
    push(2, 32'h10, 32'hA5, 1'b0);
    wait_start(1);
    finish_txn(3, 1'b0, 1'b0, 1'b1);

    // Stray wr_done in IDLE is ignored.
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("idle_done_ack", req_ack, 0);
    chk("idle_done_busy", busy, 1'b0);

    // Round robin from a fresh pointer: 0,1,2,3,0 with all requests held.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_src(i, 32'h100 + 32'(i) * 4, 32'hD0 + 32'(i));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push(i % NREQ, 32'h100 + 32'(i % NREQ) * 4, 32'hD0 + 32'(i % NREQ), 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_start(i == 0 ? 1 : 2);
      finish_txn(3, 1'b0, 1'b0, 1'b0);
    end

    // Pointer wrap: grant 3, then 1001 -> 0, then 1001 -> 3.
    req = 4'b1000;
    push(3, 32'h10C, 32'hD3, 1'b0);
    wait_start(2);
    finish_txn(2, 1'b0, 1'b0, 1'b0);
    req = 4'b1001;
    push(0, 32'h100, 32'hD0, 1'b0);
    wait_start(2);
    finish_txn(2, 1'b0, 1'b0, 1'b0);
    req = 4'b1001;
    push(3, 32'h10C, 32'hD3, 1'b0);
    wait_start(2);
    finish_txn(2, 1'b0, 1'b0, 1'b1);
    req = '0;

    // Stability after grant, with a stray wr_done during ISSUE.
    tick();
    set_src(1, 32'h2000, 32'h55);
    req = 4'b0010;
    push(1, 32'h2000, 32'h55, 1'b0);
    wait_start(1);
    finish_txn(4, 1'b1, 1'b1, 1'b1);

`ifdef WR_TIMEOUT_EN
    // Watchdog expiry, then wr_done on the expiry cycle.
    tick();
    set_src(2, 32'h3000, 32'h77);
    req = 4'b0100;
    push(2, 32'h3000, 32'h77, 1'b1);
    wait_start(1);
    finish_txn(0, 1'b0, 1'b0, 1'b1);
    tick();
    req = 4'b0100;
    push(2, 32'h3000, 32'h77, 1'b0);
    wait_start(1);
    finish_txn(TO, 1'b0, 1'b0, 1'b1);
`else
    // Without the watchdog, WAIT holds indefinitely until wr_done.
    tick();
    set_src(2, 32'h3000, 32'h77);
    req = 4'b0100;
    push(2, 32'h3000, 32'h77, 1'b0);
    wait_start(1);
    finish_txn(40, 1'b0, 1'b0, 1'b1);
`endif

    // Reset during WAIT abandons the write; pending requester 1 restarts.
    tick();
    set_src(1, 32'h4000, 32'h99);
    req = 4'b0010;
    wait_start(1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_busy", busy, 1'b0);
    chk("rst_wait_ack", req_ack, 0);
    chk("rst_wait_addr", wr_addr, 0);
    push(1, 32'h4000, 32'h99, 1'b0);
    wait_start(1);
    finish_txn(2, 1'b0, 1'b0, 1'b1);

    chk("sb_drained", sb.size(), 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
